rvecc_check_pipe: RTL
=====================

RVECC_CHECK_PIPE -- requirements
Module: rvecc_check_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter ECC_W, default $clog2(DATA_W)+2, check-bit width (7 for 32, 8 for 64); not overridden.
REQ-003 SHALL have parameter ADDR_W, default 16, width of the tag/address carried with each word.
REQ-004 SHALL have parameter CNT_W, default 8, width of the error counters.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_l, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1): upstream handshake.
REQ-008 SHALL have ports in_data (input, DATA_W), in_ecc (input, ECC_W), in_addr (input, ADDR_W): word, stored check bits, tag.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1): downstream handshake.
REQ-010 SHALL have ports out_data (output, DATA_W), out_ecc (output, ECC_W), out_addr (output, ADDR_W): checked word, check bits, tag.
REQ-011 SHALL have ports out_single_err and out_double_err (output, 1 each), qualified by out_valid.
REQ-012 SHALL have ports sb_cnt and db_cnt (output, CNT_W each): saturating single/double error counts.
REQ-013 SHALL have ports err_addr (output, ADDR_W) and err_addr_vld (output, 1): tag of the first error since clear.
REQ-014 SHALL have port cnt_clr (input, 1): synchronous clear of counters and error capture.

Function
REQ-015 SHALL use extended Hamming SEC-DED: check bits at codeword positions 2^k, data bits in the remaining positions in ascending order, and ecc[ECC_W-1] as overall parity over data and check bits.
REQ-016 SHALL compute syndrome = recomputed check bits XOR in_ecc[ECC_W-2:0], and overall = XOR of in_data and in_ecc.
REQ-017 SHALL classify: syndrome==0 and overall==0 -> clean; overall==1 -> single; syndrome!=0 and overall==0 -> double.
REQ-018 SHALL register results in one pipeline stage: a word accepted in cycle N appears on the out_* ports in cycle N+1.
REQ-019 SHALL transfer on in_valid & in_ready and on out_valid & out_ready.
REQ-020 SHALL drive in_ready = ~out_valid | out_ready; this is combinational, with no bubble at full throughput.
REQ-021 SHALL hold out_* stable while out_valid & ~out_ready.
REQ-022 SHALL clear out_valid after an output transfer when no new word is accepted in the same cycle.
REQ-023 SHALL, on double error, pass data and check bits unchanged.
REQ-024 SHALL increment sb_cnt/db_cnt once per error word accepted at the input, not at the output; counters saturate at all-ones.
REQ-025 SHALL, when err_addr_vld==0 and an error word is accepted, load err_addr with in_addr and set err_addr_vld; later errors do not overwrite it.
REQ-026 SHALL give an error accepted in the same cycle as cnt_clr priority over the clear: its counter ends at 1 and err_addr captures that word's tag.
REQ-027 SHALL NOT let cnt_clr affect the data pipeline.

Reset
REQ-028 SHALL, on rst_l low, asynchronously reset out_valid, out_single_err, out_double_err, sb_cnt, db_cnt and err_addr_vld to 0.
REQ-029 SHALL, on rst_l low, asynchronously reset out_data, out_ecc, out_addr and err_addr to 0.
REQ-030 SHALL discard a word in flight when reset asserts mid-operation; in_ready is 1 after reset.

Configuration
REQ-031 SHALL, with RV_ECC_CORRECT_EN defined, correct single errors: flip the codeword bit at position syndrome; syndrome==0 with overall==1 flips ecc[ECC_W-1].
REQ-032 SHALL, with RV_ECC_CORRECT_EN defined, deliver the corrected data on out_data and the corrected check bits on out_ecc.
REQ-033 SHALL, without RV_ECC_CORRECT_EN, perform detection only: data and check bits pass unchanged.
REQ-034 SHALL, without RV_ECC_CORRECT_EN, report any nonzero syndrome or overall as a double error; out_single_err and sb_cnt stay 0.

Verification
REQ-035 SHALL cover: DATA_W=32, in_data=0x00000000, ecc=0x00, out_ready=1 -> next cycle out_data=0, both error flags 0, counters 0.
REQ-036 SHALL cover: with the macro, in_data=0x00000001, ecc=0x00, addr=0x0040 -> out_data=0x00000000, out_single_err=1, sb_cnt=1, err_addr=0x0040, err_addr_vld=1.
REQ-037 SHALL cover: in_data=0x00000003, ecc=0x00 -> out_double_err=1, out_data=0x00000003, db_cnt=1; without the macro, the 0x00000001 case also gives out_double_err=1.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> one word held stable, in_ready=0, no loss or duplication after release.
REQ-039 SHALL cover: CNT_W=2 with 5 single-error words -> sb_cnt=3; cnt_clr together with a double error -> db_cnt=1, sb_cnt=0, err_addr = that word's tag.
REQ-040 SHALL cover: rst_l pulsed low while out_valid=1 -> out_valid=0, counters=0, in_ready=1 immediately.

Source files
------------

// File: rtl/rvecc_check_pipe.sv
// One-stage SEC-DED (extended Hamming) check pipeline with valid/ready handshake and error statistics.
// Optional single-bit correction is enabled by defining RV_ECC_CORRECT_EN.
module rvecc_check_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ECC_W  = $clog2(DATA_W) + 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ECC_W-1:0]  in_ecc,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ECC_W-1:0]  out_ecc,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_single_err,
    output logic              out_double_err,
    output logic [CNT_W-1:0]  sb_cnt,
    output logic [CNT_W-1:0]  db_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_addr_vld,
    input  logic              cnt_clr
);

    localparam int unsigned P_W  = ECC_W - 1;
    localparam int unsigned NPOS = DATA_W + P_W;

    // Codeword position of data bit idx: the idx-th non-power-of-two position from 3 upward.
    function automatic logic [P_W-1:0] data_pos(input int unsigned idx);
        int unsigned     n;
        logic [P_W-1:0]  p;
        n = 0;
        p = '0;
        for (int unsigned q = 3; q <= NPOS; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == idx) p = P_W'(q);
                n++;
            end
        end
        return p;
    endfunction

    logic [P_W-1:0]    recomputed_c;
    logic [P_W-1:0]    syndrome_c;
    logic              overall_c;
    logic              sb_err_c;
    logic              db_err_c;
    logic              err_c;
    logic              accept_c;
    logic [DATA_W-1:0] data_fix_c;
    logic [ECC_W-1:0]  ecc_fix_c;

    // Syndrome, overall parity, classification and optional correction.
    always_comb begin
        recomputed_c = '0;
        data_fix_c   = in_data;
        ecc_fix_c    = in_ecc;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (in_data[i]) recomputed_c = recomputed_c ^ data_pos(i);
        end
        syndrome_c = recomputed_c ^ in_ecc[P_W-1:0];
        overall_c  = (^in_data) ^ (^in_ecc);
`ifdef RV_ECC_CORRECT_EN
        sb_err_c = overall_c;
        db_err_c = (syndrome_c != '0) && !overall_c;
        if (overall_c) begin
            if (syndrome_c == '0) ecc_fix_c[ECC_W-1] = ~in_ecc[ECC_W-1];
            for (int unsigned k = 0; k < P_W; k++) begin
                if (syndrome_c == P_W'(1 << k)) ecc_fix_c[k] = ~in_ecc[k];
            end
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (syndrome_c == data_pos(i)) data_fix_c[i] = ~in_data[i];
            end
        end
`else
        sb_err_c = 1'b0;
        db_err_c = (syndrome_c != '0) || overall_c;
`endif
        err_c = sb_err_c || db_err_c;
    end

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Output stage: load on accept, drain when the consumer takes the word.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_ecc        <= '0;
            out_addr       <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
        end else if (accept_c) begin
            out_valid      <= 1'b1;
            out_data       <= data_fix_c;
            out_ecc        <= ecc_fix_c;
            out_addr       <= in_addr;
            out_single_err <= sb_err_c;
            out_double_err <= db_err_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics counted at the input; an error in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sb_cnt       <= '0;
            db_cnt       <= '0;
            err_addr     <= '0;
            err_addr_vld <= 1'b0;
        end else if (cnt_clr) begin
            sb_cnt       <= (accept_c && sb_err_c) ? CNT_W'(1) : '0;
            db_cnt       <= (accept_c && db_err_c) ? CNT_W'(1) : '0;
            err_addr     <= (accept_c && err_c) ? in_addr : '0;
            err_addr_vld <= accept_c && err_c;
        end else begin
            if (accept_c && sb_err_c && (sb_cnt != '1)) sb_cnt <= sb_cnt + CNT_W'(1);
            if (accept_c && db_err_c && (db_cnt != '1)) db_cnt <= db_cnt + CNT_W'(1);
            if (accept_c && err_c && !err_addr_vld) begin
                err_addr     <= in_addr;
                err_addr_vld <= 1'b1;
            end
        end
    end

endmodule
